counter_stop_sequencer: RTL and testbench

//  Upstream driver for the Counter model: queues stop targets, resets the counter, presents

---
 rtl/counter_seq_pkg.sv | 22 ++
 rtl/counter_cmd_fifo.sv | 59 +++++
 rtl/counter_stop_sequencer.sv | 131 +++++++++++++
 tb/tb_counter_stop_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types for the counter stop sequencer: FSM state encoding and the response record.
// rsp_t widths match the integration configuration of the Counter (4-bit stop, 16-bit cycles).
package counter_seq_pkg;

    localparam int SEQ_STOP_W = 4;
    localparam int SEQ_CYC_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_e;

    typedef struct packed {
        logic [SEQ_STOP_W-1:0] stop;
        logic [SEQ_CYC_W-1:0]  cycles;
        logic                  err;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/counter_cmd_fifo.sv
// Sync FIFO of stop targets; read data is registered and valid the cycle after a pop.
// Push is dropped when full, pop is ignored when empty; full does not account for a same-cycle pop.
module counter_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            o_pop_dat <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                o_pop_dat <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/counter_stop_sequencer.sv
// Runs queued stop targets on a Counter (clear, run until done or timeout) and reports elapsed cycles.
// Response held until rsp_ready; commands back up in the FIFO and cmd_ready drops when it is full.
module counter_stop_sequencer
    import counter_seq_pkg::*;
#(
    parameter int STOP_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int CYC_WIDTH  = 16,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    input  logic [STOP_WIDTH-1:0] i_cmd_stop,
    output logic                  o_cmd_ready,
    output logic                  o_ctr_reset_l,
    output logic [STOP_WIDTH-1:0] o_ctr_stop,
    input  logic                  i_ctr_done,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [STOP_WIDTH-1:0] o_rsp_stop,
    output logic [CYC_WIDTH-1:0]  o_rsp_cycles,
    output logic                  o_rsp_err,
    output logic                  o_rsp_timeout,
    output logic                  o_busy
);

    localparam logic [CYC_WIDTH-1:0] TIMEOUT_LAST = CYC_WIDTH'(TIMEOUT - 1);
    localparam logic [CYC_WIDTH-1:0] TIMEOUT_CYC  = CYC_WIDTH'(TIMEOUT);

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [STOP_WIDTH-1:0] w_fifo_dat;
    logic [CYC_WIDTH-1:0]  r_cyc;

    assign o_cmd_ready = !w_full;
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign o_busy      = (r_state != IDLE) || !w_empty;

    counter_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (STOP_WIDTH)
    ) u_cmd_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (w_push),
        .i_push_dat (i_cmd_stop),
        .i_pop      (w_pop),
        .o_pop_dat  (w_fifo_dat),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR:  w_state_nxt = RUN;
            RUN: begin
                if (i_ctr_done || (r_cyc == TIMEOUT_LAST)) begin
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (i_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_cyc         <= '0;
            o_ctr_reset_l <= 1'b0;
            o_ctr_stop    <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_stop    <= '0;
            o_rsp_cycles  <= '0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            // Counter is released only while running, so it starts from 0 on the first RUN cycle.
            o_ctr_reset_l <= (w_state_nxt == RUN);
            case (r_state)
                CLEAR: begin
                    o_ctr_stop <= w_fifo_dat;
                    r_cyc      <= '0;
                end
                RUN: begin
                    if (i_ctr_done) begin
                        o_rsp_valid   <= 1'b1;
                        o_rsp_stop    <= o_ctr_stop;
                        o_rsp_cycles  <= r_cyc;
                        o_rsp_err     <= (r_cyc != CYC_WIDTH'(o_ctr_stop));
                        o_rsp_timeout <= 1'b0;
                    end else if (r_cyc == TIMEOUT_LAST) begin
                        o_rsp_valid   <= 1'b1;
                        o_rsp_stop    <= o_ctr_stop;
                        o_rsp_cycles  <= TIMEOUT_CYC;
                        o_rsp_err     <= 1'b0;
                        o_rsp_timeout <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                REPORT: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_stop_sequencer.sv
// Bench for counter_stop_sequencer driving a behavioural Counter with selectable done faults.
// Expected responses are queued at command acceptance and compared when the response handshakes.
module tb_counter_stop_sequencer;
    import counter_seq_pkg::*;

    localparam int SW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int TO    = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [SW-1:0] cmd_stop;
    logic          cmd_ready;
    logic          ctr_reset_l;
    logic [SW-1:0] ctr_stop;
    logic          ctr_done;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [SW-1:0] rsp_stop;
    logic [CW-1:0] rsp_cycles;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;

    always #5 clk = ~clk;

    counter_stop_sequencer #(
        .STOP_WIDTH (SW),
        .DEPTH      (DEPTH),
        .CYC_WIDTH  (CW),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cmd_valid   (cmd_valid),
        .i_cmd_stop    (cmd_stop),
        .o_cmd_ready   (cmd_ready),
        .o_ctr_reset_l (ctr_reset_l),
        .o_ctr_stop    (ctr_stop),
        .i_ctr_done    (ctr_done),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_stop    (rsp_stop),
        .o_rsp_cycles  (rsp_cycles),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_timeout),
        .o_busy        (busy)
    );

    // Counter model: 0 = correct, 1 = done stuck low, 2 = done one count early
    logic [SW-1:0] cnt;
    int            mode;

    always_ff @(posedge clk) begin
        if (!ctr_reset_l) cnt <= '0;
        else              cnt <= cnt + 1'b1;
    end

    always_comb begin
        ctr_done = 1'b0;
        case (mode)
            1:       ctr_done = 1'b0;
            2:       ctr_done = (cnt == ctr_stop - SW'(1));
            default: ctr_done = (cnt == ctr_stop);
        endcase
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    int   run_cnt = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            run_cnt = 0;
        end else begin
            if (ctr_reset_l) run_cnt++;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_stop",    32'(rsp_stop),    32'(mon_e.stop));
                    chk("rsp_cycles",  32'(rsp_cycles),  32'(mon_e.cycles));
                    chk("rsp_err",     32'(rsp_err),     32'(mon_e.err));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.timeout));
                    chk("run_len", 32'(run_cnt),
                        mon_e.timeout ? 32'(TO) : 32'(mon_e.cycles) + 32'd1);
                    chk("ctr_held_in_report", 32'(ctr_reset_l), 32'd0);
                end
                run_cnt = 0;
            end
        end
    end

    task automatic send(input logic [SW-1:0] s, input logic [CW-1:0] c,
                        input logic er, input logic tmo);
        rsp_t e;
        bit   acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_stop  = s;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                e.stop    = s;
                e.cycles  = c;
                e.err     = er;
                e.timeout = tmo;
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!acc) chk("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic sendn(input logic [SW-1:0] s);
        send(s, CW'(s), 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_stop  = '0;
        rsp_ready = 1'b1;
        mode      = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctr_reset_l", 32'(ctr_reset_l), 32'd0);
        chk("rst_ctr_stop",    32'(ctr_stop),    32'd0);
        chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("rst_rsp_cycles",  32'(rsp_cycles),  32'd0);
        chk("rst_rsp_flags",   32'({rsp_err, rsp_timeout}), 32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // single job against the correct Counter
        sendn(4'd5);
        drain();

        // back-to-back including wrap extremes
        sendn(4'd0);
        sendn(4'd15);
        sendn(4'd3);
        drain();

        // fill the FIFO while the first response is stalled
        rsp_ready = 1'b0;
        sendn(4'd1);
        sendn(4'd2);
        sendn(4'd3);
        sendn(4'd4);
        sendn(4'd6);
        @(negedge clk);
        chk("cmd_ready_full", 32'(cmd_ready), 32'd0);
        chk("busy_full",      32'(busy),      32'd1);
        @(posedge clk);
        #1;
        fork
            sendn(4'd7);
            begin
                repeat (6) @(negedge clk);
                chk("cmd_held_full", 32'(cmd_ready), 32'd0);
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        drain();

        // done never arrives
        mode = 1;
        send(4'd4, CW'(TO), 1'b0, 1'b1);
        drain();
        mode = 0;
        sendn(4'd7);
        drain();

        // done one cycle early
        mode = 2;
        send(4'd6, CW'(5), 1'b1, 1'b0);
        drain();
        mode = 0;

        // reset in the middle of a run
        sendn(4'd9);
        for (int k = 0; k < 50 && !ctr_reset_l; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_run_reached", 32'(ctr_reset_l), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("mid_rst_ctr_reset_l", 32'(ctr_reset_l), 32'd0);
        chk("mid_rst_busy",        32'(busy),        32'd0);
        chk("mid_rst_cmd_ready",   32'(cmd_ready),   32'd1);
        repeat (30) @(posedge clk);
        #1;
        sendn(4'd2);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
